// File: rtl/adder_operand_seq.sv
// -----------------------------------------------------------------------------
// adder_operand_seq
//
// Purpose:
//   Collects the three operands of a 4-bit adder (in_1, in_2 and carry-in C0)
//   from four slide switches, one operand per push-button press.
//   The button is synchronized and debounced. Each debounced press produces a
//   one-clock pulse. That pulse steps a four-state sequencer:
//     S_A   --press--> capture in_1 = sw      --> S_B
//     S_B   --press--> capture in_2 = sw      --> S_C
//     S_C   --press--> capture C0 = sw[0],
//                      raise valid            --> S_RUN
//     S_RUN --press--> drop valid             --> S_A
//   The operand registers keep their values until a later state overwrites them.
//
// Ports:
//   clk    in   1  system clock; all state updates on the rising edge
//   rst    in   1  asynchronous, active-high reset
//   btn    in   1  raw, bouncy push-button (1 = pressed)
//   sw     in   4  raw slide switches (operand source)
//   in_1   out  4  registered operand A
//   in_2   out  4  registered operand B
//   C0     out  1  registered carry-in
//   valid  out  1  1 = in_1/in_2/C0 form one complete operand set
//   state  out  2  registered sequencer state (S_A=00 .. S_RUN=11)
//
// Handshake:
//   There is no ready input. valid is a level. While valid=1 the operand
//   outputs are guaranteed stable. The downstream adder may use them for as
//   long as valid stays high.
//
// Timing:
//   Suppose btn is held high and is first sampled by edge E. The pipeline is:
//     E+1                   btn_sync_q goes high
//     E+2 .. E+N            counter counts up
//     E+N+1                 debounced level toggles
//     E+N+2                 registered press pulse is raised
//     E+N+3                 sequencer/operand update
//   Here N = DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module adder_operand_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] sw,
    output logic [3:0] in_1,
    output logic [3:0] in_2,
    output logic       C0,
    output logic       valid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        S_C   = 2'b10,
        S_RUN = 2'b11
    } state_t;

    // Terminal count of the stability counter. When the counter reaches this
    // value and the input still differs, the input has been stable for
    // DEBOUNCE_CYCLES clocks in a row.
    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic       btn_meta_q, btn_sync_q;
    logic [3:0] sw_meta_q,  sw_sync_q;
    logic       level_q,     level_d;
    logic       level_dly_q, level_dly_d;
    logic [19:0] cnt_q,      cnt_d;
    logic       press_q,     press_d;
    state_t     state_q,     state_d;
    logic [3:0] in_1_q,      in_1_d;
    logic [3:0] in_2_q,      in_2_d;
    logic       c0_q,        c0_d;
    logic       valid_q,     valid_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        level_d     = level_q;
        level_dly_d = level_q;
        cnt_d       = 20'd0;
        press_d     = 1'b0;
        state_d     = state_q;
        in_1_d      = in_1_q;
        in_2_d      = in_2_q;
        c0_d        = c0_q;
        valid_d     = valid_q;

        // Debouncer. The counter only runs while the synchronized button
        // disagrees with the accepted level. Any clock on which they agree
        // restarts the stability window.
        if (btn_sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                cnt_d   = 20'd0;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end

        // Rising edge of the debounced level only. A release makes no pulse.
        // The pulse is registered, so the sequencer acts one clock after
        // the edge is detected.
        press_d = level_q & ~level_dly_q;

        if (press_q) begin
            unique case (state_q)
                S_A: begin
                    in_1_d  = sw_sync_q;
                    state_d = S_B;
                end
                S_B: begin
                    in_2_d  = sw_sync_q;
                    state_d = S_C;
                end
                S_C: begin
                    c0_d    = sw_sync_q[0];
                    valid_d = 1'b1;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    // Operands are kept. Only valid drops, so the next
                    // capture in S_A can never happen while valid=1.
                    valid_d = 1'b0;
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential block (synchronizers, debouncer and sequencer FSM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
            sw_meta_q   <= 4'd0;
            sw_sync_q   <= 4'd0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= 20'd0;
            press_q     <= 1'b0;
            state_q     <= S_A;
            in_1_q      <= 4'd0;
            in_2_q      <= 4'd0;
            c0_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            // Two-flop synchronizers. Only the *_sync_q outputs feed logic.
            btn_meta_q  <= btn;
            btn_sync_q  <= btn_meta_q;
            sw_meta_q   <= sw;
            sw_sync_q   <= sw_meta_q;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            state_q     <= state_d;
            in_1_q      <= in_1_d;
            in_2_q      <= in_2_d;
            c0_q        <= c0_d;
            valid_q     <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all taken directly from registers)
    // ------------------------------------------------------------------
    assign in_1  = in_1_q;
    assign in_2  = in_2_q;
    assign C0    = c0_q;
    assign valid = valid_q;
    assign state = state_q;

endmodule
